// File: rtl/tok_injector_if.sv
// Control and handshake bundle between the button/switch logic, the token
// injector and the entry stage of the CUES ring.
interface tok_injector_if #(
  parameter int CNT_W = 4
);
  logic             inject;
  logic [CNT_W-1:0] count;
  logic             ack_in;
  logic             req_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] sent_cnt;

  modport master (
    output inject, count, ack_in,
    input  req_out, busy, done, err, sent_cnt
  );

  modport slave (
    input  inject, count, ack_in,
    output req_out, busy, done, err, sent_cnt
  );
endinterface

// File: rtl/tok_injector.sv
// Clocked 4-phase initiator that pushes a burst of tokens into the self-timed
// ring, with a per-phase timeout that parks the block in a sticky error state.
module tok_injector #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int TO_W        = 10
) (
  input  logic          clk,
  input  logic          rst,
  tok_injector_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO, ERR} state_t;

  // The counter only has to reach all-ones, so expiry is detected one count early.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  logic [SYNC_STAGES-1:0] r_ackSync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_len;
  logic [CNT_W-1:0]       r_sentCnt;
  logic                   r_req;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic [TO_W-1:0]        r_toCnt;

  state_t                 w_stateNext;
  logic [CNT_W-1:0]       w_lenNext;
  logic [CNT_W-1:0]       w_sentNext;
  logic                   w_reqNext;
  logic                   w_busyNext;
  logic                   w_doneNext;
  logic                   w_errNext;
  logic [TO_W-1:0]        w_toNext;
  logic                   w_ackS;
  logic                   w_toExpire;
  logic [CNT_W-1:0]       w_sentInc;

  assign w_ackS     = r_ackSync[SYNC_STAGES-1];
  assign w_toExpire = (r_toCnt == TO_LAST);
  assign w_sentInc  = r_sentCnt + 1'b1;

  always_comb begin
    w_stateNext = r_state;
    w_lenNext   = r_len;
    w_sentNext  = r_sentCnt;
    w_reqNext   = r_req;
    w_busyNext  = r_busy;
    w_doneNext  = 1'b0;
    w_errNext   = r_err;
    w_toNext    = r_toCnt;
    case (r_state)
      IDLE: begin
        if (bus.inject) begin
          w_sentNext = '0;
          if (bus.count == '0) begin
            w_doneNext = 1'b1;
          end else begin
            w_lenNext   = bus.count;
            w_busyNext  = 1'b1;
            w_reqNext   = 1'b1;
            w_toNext    = '0;
            w_stateNext = REQ_HI;
          end
        end
      end
      REQ_HI: begin
        if (w_ackS) begin
          w_reqNext   = 1'b0;
          w_toNext    = '0;
          w_stateNext = REQ_LO;
        end else if (w_toExpire) begin
          w_errNext   = 1'b1;
          w_busyNext  = 1'b0;
          w_stateNext = ERR;
        end else begin
          w_toNext = r_toCnt + 1'b1;
        end
      end
      REQ_LO: begin
        if (!w_ackS) begin
          w_sentNext = w_sentInc;
          if (w_sentInc == r_len) begin
            w_doneNext  = 1'b1;
            w_busyNext  = 1'b0;
            w_stateNext = IDLE;
          end else begin
            w_reqNext   = 1'b1;
            w_toNext    = '0;
            w_stateNext = REQ_HI;
          end
        end else if (w_toExpire) begin
          w_errNext   = 1'b1;
          w_busyNext  = 1'b0;
          w_stateNext = ERR;
        end else begin
          w_toNext = r_toCnt + 1'b1;
        end
      end
      // Request level is deliberately left alone so the ring never sees a protocol break.
      ERR: begin
        w_stateNext = ERR;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ackSync <= '0;
      r_state   <= IDLE;
      r_len     <= '0;
      r_sentCnt <= '0;
      r_req     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_toCnt   <= '0;
    end else begin
      r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], bus.ack_in};
      r_state   <= w_stateNext;
      r_len     <= w_lenNext;
      r_sentCnt <= w_sentNext;
      r_req     <= w_reqNext;
      r_busy    <= w_busyNext;
      r_done    <= w_doneNext;
      r_err     <= w_errNext;
      r_toCnt   <= w_toNext;
    end
  end

  assign bus.req_out  = r_req;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.sent_cnt = r_sentCnt;

endmodule

// File: tb/tb_tok_injector.sv
// Bench for tok_injector: a ring-entry ack responder plus a handshake-level
// reference model, compared against every output on every cycle.
module tb_tok_injector;

  localparam int SYNC   = 2;
  localparam int CW     = 4;
  localparam int TW     = 10;
  localparam int TO_MAX = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int vectors     = 0;
  int miscompares = 0;
  int reqRises    = 0;
  int donePulses  = 0;

  // Ack source: tied straight to req, or echoed by the responder after a delay.
  logic ackReg     = 1'b0;
  logic ackTie     = 1'b0;
  int   ackMode    = 0;
  int   fixedDelay = 3;

  // Reference model: a token phase completes once the synchronized ack matches req.
  logic [SYNC-1:0] mPipe   = '0;
  logic            mAckS   = 1'b0;
  logic            mReq    = 1'b0;
  logic            mBusy   = 1'b0;
  logic            mDone   = 1'b0;
  logic            mErr    = 1'b0;
  logic            mDead   = 1'b0;
  logic            mActive = 1'b0;
  int              mSent   = 0;
  int              mLen    = 0;
  int              mWait   = 0;

  tok_injector_if #(.CNT_W(CW)) bus ();

  tok_injector #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CW),
    .TO_W       (TW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.ack_in = ackTie ? bus.req_out : ackReg;

  always #5 clk = ~clk;

  initial begin
    int d;
    forever begin
      @(bus.req_out);
      if (ackMode != 0) begin
        d = (ackMode == 2) ? int'($urandom_range(20, 1)) : fixedDelay;
        repeat (d) @(posedge clk);
        #($urandom_range(8, 2));
        ackReg = bus.req_out;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStep();
    mAckS = mPipe[SYNC-1];
    mPipe = {mPipe[SYNC-2:0], bus.ack_in};
    mDone = 1'b0;
    if (rst) begin
      mPipe   = '0;
      mReq    = 1'b0;
      mBusy   = 1'b0;
      mErr    = 1'b0;
      mDead   = 1'b0;
      mActive = 1'b0;
      mSent   = 0;
      mWait   = 0;
    end else if (mDead) begin
      mWait = 0;
    end else if (!mActive) begin
      if (bus.inject) begin
        mSent = 0;
        if (bus.count == 0) begin
          mDone = 1'b1;
        end else begin
          mLen    = int'(bus.count);
          mActive = 1'b1;
          mBusy   = 1'b1;
          mReq    = 1'b1;
          mWait   = 0;
        end
      end
    end else if (mAckS == mReq) begin
      mWait = 0;
      if (mReq) begin
        mReq = 1'b0;
      end else begin
        mSent++;
        if (mSent == mLen) begin
          mDone   = 1'b1;
          mBusy   = 1'b0;
          mActive = 1'b0;
        end else begin
          mReq = 1'b1;
        end
      end
    end else begin
      mWait++;
      if (mWait == TO_MAX) begin
        mDead = 1'b1;
        mErr  = 1'b1;
        mBusy = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive inputs, let the edge happen, then compare everything.
  task automatic applyStimulus(input logic r, input logic inj, input logic [CW-1:0] cnt);
    logic prevReq;
    logic wasActive;
    rst        = r;
    bus.inject = inj;
    bus.count  = cnt;
    prevReq    = bus.req_out;
    wasActive  = mActive && !mDead;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("req_out", {31'd0, bus.req_out}, {31'd0, mReq});
    checkOutput("busy", {31'd0, bus.busy}, {31'd0, mBusy});
    checkOutput("done", {31'd0, bus.done}, {31'd0, mDone});
    checkOutput("err", {31'd0, bus.err}, {31'd0, mErr});
    checkOutput("sent_cnt", {28'd0, bus.sent_cnt}, 32'(mSent));
    if (bus.req_out === 1'b1 && prevReq === 1'b0) reqRises++;
    if (bus.done === 1'b1) donePulses++;
    if (!r && wasActive && bus.req_out !== prevReq)
      checkOutput("phaseOrder", {31'd0, mAckS}, {31'd0, prevReq});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, bus.count);
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && bus.busy === 1'b1; i++) idle(1);
    checkOutput("burstEnd", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    bus.inject = 1'b0;
    bus.count  = '0;

    applyStimulus(1'b1, 1'b0, 4'd0);
    applyStimulus(1'b1, 1'b0, 4'd0);
    checkOutput("rstReq", {31'd0, bus.req_out}, 32'd0);
    checkOutput("rstSent", {28'd0, bus.sent_cnt}, 32'd0);
    idle(2);

    $display("[TB] basic burst of 3, ack echoed after 3 cycles");
    ackMode = 1; fixedDelay = 3; reqRises = 0; donePulses = 0;
    applyStimulus(1'b0, 1'b1, 4'd3);
    waitIdle(300);
    checkOutput("basicRises", 32'(reqRises), 32'd3);
    checkOutput("basicSent", {28'd0, bus.sent_cnt}, 32'd3);
    checkOutput("basicDone", 32'(donePulses), 32'd1);
    checkOutput("basicReqEnd", {31'd0, bus.req_out}, 32'd0);
    idle(6);

    $display("[TB] latency with ack tied to req");
    ackMode = 0; ackTie = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'd1);
    checkOutput("latRise", {31'd0, bus.req_out}, 32'd1);
    idle(2);
    checkOutput("latHold", {31'd0, bus.req_out}, 32'd1);
    idle(1);
    checkOutput("latFall", {31'd0, bus.req_out}, 32'd0);
    idle(2);
    checkOutput("latNoDone", {31'd0, bus.done}, 32'd0);
    idle(1);
    checkOutput("latDone", {31'd0, bus.done}, 32'd1);
    ackTie = 1'b0; ackReg = 1'b0;
    idle(4);

    $display("[TB] zero-length burst");
    applyStimulus(1'b0, 1'b1, 4'd0);
    checkOutput("zeroDone", {31'd0, bus.done}, 32'd1);
    checkOutput("zeroBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("zeroReq", {31'd0, bus.req_out}, 32'd0);
    idle(1);
    checkOutput("zeroDoneOnce", {31'd0, bus.done}, 32'd0);

    $display("[TB] spurious ack while idle");
    ackReg = 1'b1;
    idle(5);
    ackReg = 1'b0;
    idle(4);
    checkOutput("spurErr", {31'd0, bus.err}, 32'd0);

    $display("[TB] inject while busy, then reset mid-burst");
    ackMode = 1; fixedDelay = 2; reqRises = 0;
    applyStimulus(1'b0, 1'b1, 4'd4);
    idle(8);
    applyStimulus(1'b0, 1'b1, 4'd5);
    waitIdle(300);
    checkOutput("busySent", {28'd0, bus.sent_cnt}, 32'd4);
    checkOutput("busyRises", 32'(reqRises), 32'd4);
    idle(4);
    applyStimulus(1'b0, 1'b1, 4'd6);
    for (int i = 0; i < 300 && !(bus.sent_cnt >= 4'd2 && bus.req_out === 1'b1); i++) idle(1);
    checkOutput("midBurstReq", {31'd0, bus.req_out}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'd6);
    checkOutput("rstMidReq", {31'd0, bus.req_out}, 32'd0);
    checkOutput("rstMidSent", {28'd0, bus.sent_cnt}, 32'd0);
    checkOutput("rstMidBusy", {31'd0, bus.busy}, 32'd0);
    idle(30);
    ackMode = 0; ackReg = 1'b0;
    idle(4);

    $display("[TB] handshake timeout with ack held low");
    applyStimulus(1'b0, 1'b1, 4'd2);
    idle(TO_MAX - 1);
    checkOutput("toBefore", {31'd0, bus.err}, 32'd0);
    idle(1);
    checkOutput("toErr", {31'd0, bus.err}, 32'd1);
    checkOutput("toBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("toReq", {31'd0, bus.req_out}, 32'd1);
    applyStimulus(1'b0, 1'b1, 4'd1);
    idle(3);
    checkOutput("errInjBusy", {31'd0, bus.busy}, 32'd0);
    checkOutput("errInjReq", {31'd0, bus.req_out}, 32'd1);
    applyStimulus(1'b1, 1'b0, 4'd0);
    checkOutput("errRstErr", {31'd0, bus.err}, 32'd0);
    checkOutput("errRstReq", {31'd0, bus.req_out}, 32'd0);
    idle(4);

    $display("[TB] asynchronous ack with random delay and skew");
    ackMode = 2; reqRises = 0; donePulses = 0;
    applyStimulus(1'b0, 1'b1, 4'd15);
    waitIdle(3000);
    checkOutput("asyncSent", {28'd0, bus.sent_cnt}, 32'd15);
    checkOutput("asyncRises", 32'(reqRises), 32'd15);
    checkOutput("asyncDone", 32'(donePulses), 32'd1);
    checkOutput("asyncErr", {31'd0, bus.err}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      idle(int'($urandom_range(6, 1)));
      n = int'($urandom_range(15, 1));
      reqRises = 0;
      applyStimulus(1'b0, 1'b1, 4'(n));
      waitIdle(3000);
      checkOutput("randSent", {28'd0, bus.sent_cnt}, 32'(n));
      checkOutput("randRises", 32'(reqRises), 32'(n));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
